muldiv_unit: RTL

- Parametrised multi-cycle RV32M/RV64M execution unit. It is the sequential successor to the single-cycle M-extension decode path.
- It takes the M funct3 directly and computes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Multiply uses iterative shift-add, or single-cycle when FAST_MUL=1. Divide uses iterative restoring radix-2.
- It sits beside the ALU in the execute stage. The core stalls on busy and consumes result on done.

---
 rtl/muldiv_unit.sv | 139 +++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: shift-add multiply (single-cycle when
// FAST_MUL), restoring radix-2 divide, sign fix-up and result select in a FIX cycle.
module muldiv_unit #(
  parameter int XLEN     = 32,
  parameter bit FAST_MUL = 1'b0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int              CW       = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_n;
  logic [CW-1:0]     counter;
  logic [2:0]        op_q;
  logic              sign_a_q, sign_b_q, special_q;
  logic [XLEN-1:0]   a_mag_q, b_mag_q;
  logic [2*XLEN-1:0] acc;

  logic            accept, is_div_in, a_signed_in, b_signed_in, sign_a_in, sign_b_in;
  logic            div_zero_in, overflow_in, special_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in, special_val;

  assign busy        = (state != IDLE);
  assign accept      = start && !kill && (state == IDLE);
  assign is_div_in   = funct3[2];
  assign a_signed_in = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                       (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed_in = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sign_a_in   = a_signed_in && operand_a[XLEN-1];
  assign sign_b_in   = b_signed_in && operand_b[XLEN-1];
  assign a_mag_in    = sign_a_in ? -operand_a : operand_a;
  assign b_mag_in    = sign_b_in ? -operand_b : operand_b;
  assign div_zero_in = is_div_in && (operand_b == '0);
  assign overflow_in = is_div_in && !funct3[0] && (operand_a == MOST_NEG) && (operand_b == '1);
  assign special_in  = div_zero_in || overflow_in;
  // funct3[1] distinguishes remainder from quotient among the divide ops.
  assign special_val = div_zero_in ? (funct3[1] ? operand_a : '1)
                                   : (funct3[1] ? '0 : MOST_NEG);

  // One iteration: multiply keeps the multiplier in the low half and shifts right;
  // divide keeps remainder high / dividend-then-quotient low and shifts left.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag_q} : '0);
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, b_mag_q};
    div_ok    = !div_diff[XLEN];
    if (op_q[2])
      acc_step = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ok};
    else
      acc_step = {mul_sum, acc[XLEN-1:1]};
  end

  logic [2*XLEN-1:0] product, product_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_val;

  // NOTE: every combinational output gets a default before any branch, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    product = acc;
    if (FAST_MUL) product = {{XLEN{1'b0}}, a_mag_q} * {{XLEN{1'b0}}, b_mag_q};
    product_s = (sign_a_q ^ sign_b_q) ? -product : product;
    quo_s     = (sign_a_q ^ sign_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_s     = sign_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_val   = rem_s;
    if (special_q) begin
      fix_val = acc[XLEN-1:0];
    end else begin
      case (op_q)
        3'b000:                 fix_val = product_s[XLEN-1:0];
        3'b001, 3'b010, 3'b011: fix_val = product_s[2*XLEN-1:XLEN];
        3'b100, 3'b101:         fix_val = quo_s;
        default:                fix_val = rem_s;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept) state_n = (special_in || (FAST_MUL && !is_div_in)) ? FIX : CALC;
      CALC: if (counter == CW'(1)) state_n = FIX;
      FIX:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (kill) state_n = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      result  <= '0;
      counter <= '0;
    end else begin
      state <= state_n;
      done  <= (state == FIX) && !kill;
      if ((state == FIX) && !kill) result <= fix_val;
      if (accept)              counter <= CW'(XLEN);
      else if (state == CALC)  counter <= counter - CW'(1);
    end
  end

  // NOTE: operand/accumulator registers are deliberately not reset; they are always
  // loaded on acceptance before being read.
  always_ff @(posedge clock) begin
    if (accept) begin
      op_q      <= funct3;
      sign_a_q  <= sign_a_in;
      sign_b_q  <= sign_b_in;
      a_mag_q   <= a_mag_in;
      b_mag_q   <= b_mag_in;
      special_q <= special_in;
      if (special_in)     acc <= {{XLEN{1'b0}}, special_val};
      else if (is_div_in) acc <= {{XLEN{1'b0}}, a_mag_in};
      else                acc <= {{XLEN{1'b0}}, b_mag_in};
    end else if (state == CALC) begin
      acc <= acc_step;
    end
  end

endmodule
